// File: rtl/csb_seq.sv
// Layer command sequencer: pulls CMD_BURST_LEN-word bursts from the command FIFO,
// sanity-checks each layer, hands it to the engine and waits for op_done.
module csb_seq #(
   parameter int unsigned CMD_BURST_LEN = 3,
   parameter int unsigned LAYER_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_en,
   input  logic               abort,
   input  logic [LAYER_W-1:0] num_layers,
   input  logic               valid,
   output logic               rd_en,
   input  logic [31:0]        cmd,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   input  logic               op_done,
   output logic [2:0]         op_type,
   output logic [3:0]         stride,
   output logic [7:0]         kernel,
   output logic [7:0]         i_side,
   output logic [7:0]         o_side,
   output logic [15:0]        i_channel,
   output logic [15:0]        o_channel,
   output logic [7:0]         kernel_size,
   output logic [15:0]        stride2,
   output logic [LAYER_W-1:0] layer_idx,
   output logic [2:0]         curr_state,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam int unsigned   CW        = $clog2(CMD_BURST_LEN + 1);
   localparam logic [CW-1:0] BURST     = CW'(CMD_BURST_LEN);
   localparam logic [CW-1:0] LAST_WORD = CW'(CMD_BURST_LEN - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      FETCH = 3'b001,
      CHECK = 3'b010,
      ISSUE = 3'b011,
      RUN   = 3'b100,
      DONE  = 3'b101,
      ERR   = 3'b110
   } state_t;

   state_t             state;
   logic [CW-1:0]      req_cnt;
   logic [CW-1:0]      word_cnt;
   logic [CW-1:0]      req_nxt;
   logic [LAYER_W-1:0] num_q;
   logic [LAYER_W-1:0] idx_nxt;

   logic [2:0]  sh_op;
   logic [3:0]  sh_stride;
   logic [7:0]  sh_kernel;
   logic [7:0]  sh_iside;
   logic [7:0]  sh_oside;
   logic [15:0] sh_ich;
   logic [15:0] sh_och;
   logic [7:0]  sh_ks;
   logic [15:0] sh_s2;
   logic [15:0] prod;
   logic        check_ok;

   // Reserved command bits, never decoded.
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^{cmd[3], cmd[7:0]};

   always_comb begin
      req_nxt  = req_cnt + {{(CW-1){1'b0}}, rd_en};
      idx_nxt  = layer_idx + LAYER_W'(1);
      prod     = {8'b0, sh_kernel} * {12'b0, sh_stride};
      check_ok = ((sh_op == 3'b001) || (sh_op == 3'b100) || (sh_op == 3'b101)) &&
                 (sh_stride != 4'd0) &&
                 ({4'b0, sh_stride} <= sh_kernel) &&
                 (sh_s2 == prod);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rd_en       <= 1'b0;
         cmd_valid   <= 1'b0;
         req_cnt     <= '0;
         word_cnt    <= '0;
         num_q       <= '0;
         layer_idx   <= '0;
         sh_op       <= '0;
         sh_stride   <= '0;
         sh_kernel   <= '0;
         sh_iside    <= '0;
         sh_oside    <= '0;
         sh_ich      <= '0;
         sh_och      <= '0;
         sh_ks       <= '0;
         sh_s2       <= '0;
         op_type     <= '0;
         stride      <= '0;
         kernel      <= '0;
         i_side      <= '0;
         o_side      <= '0;
         i_channel   <= '0;
         o_channel   <= '0;
         kernel_size <= '0;
         stride2     <= '0;
      end else if (abort) begin
         // Words still in flight land while IDLE and are dropped there.
         state     <= IDLE;
         rd_en     <= 1'b0;
         cmd_valid <= 1'b0;
         req_cnt   <= '0;
         word_cnt  <= '0;
         layer_idx <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (op_en) begin
                  num_q    <= num_layers;
                  req_cnt  <= '0;
                  word_cnt <= '0;
                  if (num_layers != '0) begin
                     layer_idx <= '0;
                     rd_en     <= 1'b1;
                     state     <= FETCH;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            FETCH: begin
               req_cnt <= req_nxt;
               rd_en   <= (req_nxt < BURST);
               if (valid) begin
                  if (word_cnt == CW'(0)) begin
                     sh_op     <= cmd[2:0];
                     sh_stride <= cmd[7:4];
                     sh_kernel <= cmd[15:8];
                     sh_iside  <= cmd[23:16];
                     sh_oside  <= cmd[31:24];
                  end
                  if (word_cnt == CW'(1)) begin
                     sh_ich <= cmd[15:0];
                     sh_och <= cmd[31:16];
                  end
                  if (word_cnt == CW'(2)) begin
                     sh_ks <= cmd[15:8];
                     sh_s2 <= cmd[31:16];
                  end
                  word_cnt <= word_cnt + CW'(1);
                  if (word_cnt == LAST_WORD) state <= CHECK;
               end
            end
            CHECK: begin
               if (check_ok) begin
                  op_type     <= sh_op;
                  stride      <= sh_stride;
                  kernel      <= sh_kernel;
                  i_side      <= sh_iside;
                  o_side      <= sh_oside;
                  i_channel   <= sh_ich;
                  o_channel   <= sh_och;
                  kernel_size <= sh_ks;
                  stride2     <= sh_s2;
                  cmd_valid   <= 1'b1;
                  state       <= ISSUE;
               end else begin
                  state <= ERR;
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (op_done) begin
                  // The final layer keeps its index so layer_idx names the last layer run.
                  if (idx_nxt == num_q) begin
                     state <= DONE;
                  end else begin
                     layer_idx <= idx_nxt;
                     req_cnt   <= '0;
                     word_cnt  <= '0;
                     rd_en     <= 1'b1;
                     state     <= FETCH;
                  end
               end
            end
            DONE: state <= IDLE;
            ERR: begin
               rd_en     <= 1'b0;
               cmd_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign curr_state = state;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign err        = (state == ERR);

endmodule

// File: tb/tb_csb_seq.sv
// Randomised bench for csb_seq: two lanes (burst length 3 and 4) fed by a FIFO model,
// checked against a layer-level model of legality, read counts and handshake timing.
module tb_csb_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // A layer is runnable when its opcode is known and stride2 holds kernel*stride.
   function automatic bit legal(input logic [31:0] w0, input logic [31:0] w2);
      int unsigned op, s, k, s2;
      op = w0[2:0];
      s  = w0[7:4];
      k  = w0[15:8];
      s2 = w2[31:16];
      return (op == 1 || op == 4 || op == 5) && (s != 0) && (s <= k) && (s2 == k * s);
   endfunction

   task automatic gen_job(input int unsigned n, input int unsigned len, input int unsigned bad_at,
                          output logic [31:0] q[$]);
      int unsigned k, s, op, s2;
      int unsigned bad_ops[5];
      bad_ops = '{0, 2, 3, 6, 7};
      q.delete();
      for (int unsigned l = 0; l < n; l++) begin
         k = $urandom_range(1, 255);
         s = $urandom_range(1, (k < 15) ? k : 15);
         case ($urandom_range(0, 2))
            0: op = 1;
            1: op = 4;
            default: op = 5;
         endcase
         s2 = k * s;
         if (l == bad_at) begin
            case ($urandom_range(0, 3))
               0: op = bad_ops[$urandom_range(0, 4)];
               1: begin s = 0; s2 = 0; end
               2: begin k = $urandom_range(1, 14); s = $urandom_range(k + 1, 15); s2 = k * s; end
               default: s2 = k * s + $urandom_range(1, 7);
            endcase
         end
         q.push_back(($urandom() & 32'hFFFF_0008) | (k << 8) | (s << 4) | op);
         q.push_back($urandom());
         q.push_back((s2 << 16) | ($urandom() & 32'h0000_FFFF));
         for (int unsigned i = 3; i < len; i++) q.push_back($urandom());
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int unsigned LEN = 3 + g;

      logic        op_en, abort, valid, cmd_ready, op_done;
      logic [7:0]  num_layers;
      logic [31:0] cmd;
      logic        rd_en, cmd_valid, busy, done, err;
      logic [2:0]  op_type, curr_state;
      logic [3:0]  stride;
      logic [7:0]  kernel, i_side, o_side, kernel_size, layer_idx;
      logic [15:0] i_channel, o_channel, stride2;

      logic [31:0] stream[$];
      logic [31:0] pending[$];
      int unsigned rd_cnt = 0;
      int unsigned gap = 0;
      int unsigned last_valid_cyc = 0;
      logic [31:0] last_w0 = '0, last_w1 = '0, last_w2 = '0;
      bit          fin = 1'b0;
      int unsigned jn, jbad;
      logic [31:0] jq[$];

      csb_seq #(.CMD_BURST_LEN(LEN), .LAYER_W(8)) dut (
         .clk(clk), .rst(rst), .op_en(op_en), .abort(abort), .num_layers(num_layers),
         .valid(valid), .rd_en(rd_en), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
         .op_done(op_done), .op_type(op_type), .stride(stride), .kernel(kernel),
         .i_side(i_side), .o_side(o_side), .i_channel(i_channel), .o_channel(o_channel),
         .kernel_size(kernel_size), .stride2(stride2), .layer_idx(layer_idx),
         .curr_state(curr_state), .busy(busy), .done(done), .err(err)
      );

      // FIFO: each accepted read returns one stream word, in order, after a random 0-4 cycle gap.
      initial begin : fifo
         valid = 1'b0;
         cmd   = '0;
         forever begin
            @(negedge clk);
            valid = 1'b0;
            if (pending.size() != 0) begin
               if (gap != 0) gap--;
               else begin
                  valid = 1'b1;
                  cmd = pending.pop_front();
                  last_valid_cyc = cyc;
                  gap = $urandom_range(0, 4);
               end
            end
            if (rd_en) begin
               rd_cnt++;
               pending.push_back((stream.size() != 0) ? stream.pop_front() : 32'hDEAD_BEEF);
            end
         end
      end

      task automatic drain();
         for (int i = 0; i < 100 && pending.size() != 0; i++) @(negedge clk);
         @(negedge clk);
         check_eq("fifo_drain", pending.size(), 0);
         stream.delete();
      endtask

      task automatic wait_evt(output bit ok);
         ok = 1'b0;
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_valid || err) begin
               ok = 1'b1;
               break;
            end
         end
      endtask

      task automatic run_job(input int unsigned n, input logic [31:0] words[$]);
         int unsigned n_fetch, d;
         bit          failed, ok;
         logic [31:0] w0, w1, w2;
         n_fetch = 0;
         failed  = 1'b0;
         for (int unsigned l = 0; l < n; l++) begin
            n_fetch++;
            if (!legal(words[l*LEN], words[l*LEN+2])) begin
               failed = 1'b1;
               break;
            end
         end
         stream = words;
         rd_cnt = 0;
         num_layers = 8'(n);
         op_en = 1'b1;
         @(negedge clk);
         op_en = 1'b0;
         if (n == 0) begin
            check_eq("zero_done", done, 1);
            check_eq("zero_state", curr_state, 3'b101);
            @(negedge clk);
            check_eq("zero_done_pulse", done, 0);
            check_eq("zero_idle", curr_state, 3'b000);
            check_eq("zero_reads", rd_cnt, 0);
            return;
         end
         check_eq("first_rd", rd_en, 1);
         for (int unsigned l = 0; l < n_fetch; l++) begin
            w0 = words[l*LEN];
            w1 = words[l*LEN+1];
            w2 = words[l*LEN+2];
            wait_evt(ok);
            check_eq("evt_timeout", ok, 1);
            if (!ok) begin
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               drain();
               return;
            end
            check_eq("valid_latency", cyc - last_valid_cyc, 2);
            check_eq("layer_reads", rd_cnt, (l + 1) * LEN);
            if (failed && l == n_fetch - 1) begin
               check_eq("err_flag", err, 1);
               check_eq("err_state", curr_state, 3'b110);
               check_eq("err_no_valid", cmd_valid, 0);
               check_eq("err_op_hold", op_type, last_w0[2:0]);
               check_eq("err_s2_hold", stride2, last_w2[31:16]);
               repeat (3) @(negedge clk);
               check_eq("err_sticky", err, 1);
               check_eq("err_no_rd", rd_en, 0);
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               check_eq("abort_idle", curr_state, 3'b000);
               check_eq("abort_err_clr", err, 0);
            end else begin
               check_eq("issue_err", err, 0);
               check_eq("issue_state", curr_state, 3'b011);
               check_eq("layer_idx", layer_idx, l);
               check_eq("op_type", op_type, w0[2:0]);
               check_eq("stride", stride, w0[7:4]);
               check_eq("kernel", kernel, w0[15:8]);
               check_eq("i_side", i_side, w0[23:16]);
               check_eq("o_side", o_side, w0[31:24]);
               check_eq("i_channel", i_channel, w1[15:0]);
               check_eq("o_channel", o_channel, w1[31:16]);
               check_eq("kernel_size", kernel_size, w2[15:8]);
               check_eq("stride2", stride2, w2[31:16]);
               last_w0 = w0;
               last_w1 = w1;
               last_w2 = w2;
               d = $urandom_range(0, 3);
               for (int unsigned i = 0; i < d; i++) begin
                  op_done = (i == 0);
                  @(negedge clk);
                  check_eq("hold_valid", cmd_valid, 1);
               end
               op_done   = 1'b0;
               cmd_ready = 1'b1;
               @(negedge clk);
               cmd_ready = 1'b0;
               check_eq("run_state", curr_state, 3'b100);
               check_eq("valid_drop", cmd_valid, 0);
               d = $urandom_range(0, 5);
               repeat (d) @(negedge clk);
               check_eq("run_kernel_stable", kernel, w0[15:8]);
               op_done = 1'b1;
               @(negedge clk);
               op_done = 1'b0;
               if (l == n - 1) begin
                  check_eq("done_pulse", done, 1);
                  check_eq("done_state", curr_state, 3'b101);
                  @(negedge clk);
                  check_eq("done_once", done, 0);
                  check_eq("idle_after_done", curr_state, 3'b000);
                  check_eq("idle_busy", busy, 0);
               end else begin
                  check_eq("next_fetch", curr_state, 3'b001);
                  check_eq("next_rd", rd_en, 1);
                  check_eq("next_idx", layer_idx, l + 1);
               end
            end
         end
         drain();
         check_eq("total_reads", rd_cnt, n_fetch * LEN);
      endtask

      task automatic dir_job(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
         logic [31:0] q[$];
         q = {w0, w1, w2};
         for (int unsigned i = 3; i < LEN; i++) q.push_back($urandom());
         run_job(1, q);
      endtask

      task automatic abort_mid_fetch();
         logic [31:0] q[$];
         gen_job(2, LEN, 99, q);
         stream = q;
         rd_cnt = 0;
         num_layers = 8'd2;
         op_en = 1'b1;
         @(negedge clk);
         op_en = 1'b0;
         check_eq("abort_rd1", rd_en, 1);
         @(negedge clk);
         check_eq("abort_rd2", rd_en, 1);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         check_eq("abort_fetch_idle", curr_state, 3'b000);
         check_eq("abort_rd_off", rd_en, 0);
         check_eq("abort_busy", busy, 0);
         repeat (12) @(negedge clk);
         check_eq("late_valid_ignored", curr_state, 3'b000);
         check_eq("abort_reads", rd_cnt, 2);
         drain();
      endtask

      initial begin : stim
         op_en      = 1'b0;
         abort      = 1'b0;
         num_layers = '0;
         cmd_ready  = 1'b0;
         op_done    = 1'b0;
         wait (rst == 1'b0);
         @(negedge clk);
         check_eq("rst_state", curr_state, 3'b000);
         check_eq("rst_rd_en", rd_en, 0);
         check_eq("rst_cmd_valid", cmd_valid, 0);
         check_eq("rst_busy", busy, 0);
         check_eq("rst_done", done, 0);
         check_eq("rst_err", err, 0);
         check_eq("rst_layer_idx", layer_idx, 0);
         check_eq("rst_stride2", stride2, 0);
         op_done = 1'b1;
         @(negedge clk);
         op_done = 1'b0;
         check_eq("idle_op_done", curr_state, 3'b000);

         dir_job(32'h0E0E0301, 32'h00400010, 32'h00030900);
         dir_job(32'h0E0E0311, 32'h00400010, 32'h00030900);
         dir_job(32'h0E0E0312, 32'h00400010, 32'h00030900);
         dir_job(32'h0E0E0311, 32'h00400010, 32'h00040900);
         jq.delete();
         run_job(0, jq);
         abort_mid_fetch();
         dir_job(32'h0E0E0311, 32'h00400010, 32'h00030900);

         for (int unsigned j = 0; j < 10; j++) begin
            jn   = $urandom_range(1, 4);
            jbad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, jn - 1) : jn;
            gen_job(jn, LEN, jbad, jq);
            run_job(jn, jq);
         end
         fin = 1'b1;
      end
   end

   initial begin : top
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50000 && !(lane[0].fin && lane[1].fin); i++) @(negedge clk);
      check_eq("global_timeout", {31'b0, lane[0].fin && lane[1].fin}, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
